instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_if.sv | 27 ++
 rtl/instr_fetch.sv | 112 +++++++++++
 tb/tb_instr_fetch.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Fetch-unit bundle: instruction-memory request/ack, decoder head handoff, redirect and stall.
// master = fetch unit, slave = memory/decoder/branch side.
interface instr_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, opcode, funct, instr_pc,
    input  imem_ack, imem_rdata, instr_ready, redirect, redirect_pc, stall
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, opcode, funct, instr_pc,
    output imem_ack, imem_rdata, instr_ready, redirect, redirect_pc, stall
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: one outstanding memory read feeding a 2-entry buffer; ack-to-valid latency 1 cycle.
// Decoder backpressure stops new requests once two words are held; stall blocks issue only.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  instr_fetch_if.master bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, FLUSH = 2'd2} state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic [31:0] req_addr;
  logic        req_q;
  logic [1:0]  count;
  logic [31:0] head_dat;
  logic [31:0] head_pc;
  logic [31:0] tail_dat;
  logic [31:0] tail_pc;

  logic        ack;
  logic        redir;
  logic        push;
  logic        pop;
  logic        issue;
  logic [31:0] target;

  assign ack    = bus.imem_ack & req_q;
  assign redir  = bus.redirect & (state != IDLE);
  assign push   = (state == FETCH) & ack & ~redir;
  assign pop    = (count != 2'd0) & bus.instr_ready;
  assign issue  = (state == FETCH) & ~req_q & ~bus.stall & ~redir & (count <= 2'd1);
  assign target = bus.redirect_pc & 32'hFFFF_FFFC;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
      req_q    <= 1'b0;
      count    <= 2'd0;
      head_dat <= 32'd0;
      head_pc  <= 32'd0;
      tail_dat <= 32'd0;
      tail_pc  <= 32'd0;
    end else begin
      case (state)
        IDLE:    state <= FETCH;
        FETCH:   if (redir && req_q && !ack) state <= FLUSH;
        FLUSH:   if (ack) state <= FETCH;
        default: state <= IDLE;
      endcase

      if (ack) begin
        req_q <= 1'b0;
      end else if (issue) begin
        req_q    <= 1'b1;
        req_addr <= fetch_pc;
      end

      if (redir) begin
        fetch_pc <= target;
      end else if (push) begin
        fetch_pc <= fetch_pc + 32'd4;
      end

      // A redirect discards everything buffered, including any word popped this cycle.
      if (redir) begin
        count <= 2'd0;
      end else begin
        case ({push, pop})
          2'b10: begin
            if (count == 2'd0) begin
              head_dat <= bus.imem_rdata;
              head_pc  <= fetch_pc;
            end else begin
              tail_dat <= bus.imem_rdata;
              tail_pc  <= fetch_pc;
            end
            count <= count + 2'd1;
          end
          2'b01: begin
            head_dat <= tail_dat;
            head_pc  <= tail_pc;
            count    <= count - 2'd1;
          end
          2'b11: begin
            if (count == 2'd1) begin
              head_dat <= bus.imem_rdata;
              head_pc  <= fetch_pc;
            end else begin
              head_dat <= tail_dat;
              head_pc  <= tail_pc;
              tail_dat <= bus.imem_rdata;
              tail_pc  <= fetch_pc;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = req_q ? req_addr : fetch_pc;
  assign bus.instr_valid = (count != 2'd0);
  assign bus.instr       = head_dat;
  assign bus.opcode      = head_dat[31:26];
  assign bus.funct       = head_dat[5:0];
  assign bus.instr_pc    = head_pc;
endmodule

// File: tb/tb_instr_fetch.sv
// Randomised and directed bench for instr_fetch with a queue-based reference model.
module tb_instr_fetch;
  typedef logic [31:0] addrq_t[$];
  typedef struct packed { logic [31:0] w; logic [31:0] pc; } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_if bus();
  instr_fetch_if wbus();

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut    (.clk(clk), .rst(rst), .bus(bus));
  instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (.clk(clk), .rst(rst), .bus(wbus));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] qat(input addrq_t q, input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_DEAD;
  endfunction

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Reference model: buffer as a queue, one outstanding-request flag, flush flag.
  ent_t        mq[$];
  bit          m_idle, m_out, m_flush, m_acked, m_can;
  int          m_n;
  logic [31:0] m_pc, m_addr, m_old_pc;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      m_idle = 1; m_out = 0; m_flush = 0;
      m_pc = 32'h0; m_addr = 32'h0;
    end else if (m_idle) begin
      m_idle = 0;
    end else begin
      m_n      = mq.size();
      m_old_pc = m_pc;
      m_acked  = m_out && bus.imem_ack;
      m_can    = !m_out && !bus.stall && !bus.redirect && (m_n <= 1);
      if (bus.redirect) begin
        mq.delete();
        m_flush = m_out && !m_acked;
        m_pc    = bus.redirect_pc & 32'hFFFF_FFFC;
      end else begin
        if (m_n > 0 && bus.instr_ready) void'(mq.pop_front());
        if (m_acked) begin
          if (!m_flush) begin
            mq.push_back({bus.imem_rdata, m_pc});
            m_pc = m_pc + 32'd4;
          end
          m_flush = 0;
        end
      end
      if (m_acked) m_out = 0;
      else if (m_can) begin m_out = 1; m_addr = m_old_pc; end
    end
  end

  addrq_t req_log, acc_log, w_req_log, w_acc_log;
  bit     prev_req, w_prev_req;

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_req", bus.imem_req, 1'b0);
      chk("rst_addr", bus.imem_addr, 32'h0);
      chk("rst_valid", bus.instr_valid, 1'b0);
      chk("rst_instr", bus.instr, 32'h0);
      chk("rst_pc", bus.instr_pc, 32'h0);
      prev_req = 0;
    end else begin
      chk("imem_req", bus.imem_req, m_out);
      if (m_out) chk("imem_addr", bus.imem_addr, m_addr);
      chk("instr_valid", bus.instr_valid, mq.size() != 0);
      if (mq.size() != 0) begin
        chk("instr", bus.instr, mq[0].w);
        chk("instr_pc", bus.instr_pc, mq[0].pc);
        chk("opcode", {26'd0, bus.opcode}, {26'd0, mq[0].w[31:26]});
        chk("funct", {26'd0, bus.funct}, {26'd0, mq[0].w[5:0]});
      end
      if (bus.imem_req && !prev_req) req_log.push_back(bus.imem_addr);
      prev_req = bus.imem_req;
      if (bus.instr_valid && bus.instr_ready) acc_log.push_back(bus.instr_pc);
    end
  end

  always @(negedge clk) begin
    if (!rst) w_prev_req = 0;
    else begin
      if (wbus.imem_req && !w_prev_req) w_req_log.push_back(wbus.imem_addr);
      w_prev_req = wbus.imem_req;
      if (wbus.instr_valid && wbus.instr_ready) w_acc_log.push_back(wbus.instr_pc);
    end
  end

  // Wrap instance: always ready, memory answers one cycle after each request.
  initial begin
    wbus.imem_ack = 0; wbus.imem_rdata = 0; wbus.instr_ready = 1;
    wbus.redirect = 0; wbus.redirect_pc = 0; wbus.stall = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst) wbus.imem_ack = 0;
      else wbus.imem_ack = wbus.imem_req && !wbus.imem_ack;
      wbus.imem_rdata = word_of(wbus.imem_addr);
    end
  end

  int lat_lo, lat_hi, lat, p_rdy, p_stall, p_redir;
  bit busy, rand_mode;

  task automatic step();
    int sel;
    @(posedge clk); #1;
    if (!rst || bus.imem_ack) begin
      bus.imem_ack = 0; busy = 0;
    end else if (bus.imem_req) begin
      if (!busy) begin busy = 1; lat = $urandom_range(lat_hi, lat_lo); end
      if (lat == 0) bus.imem_ack = 1;
      else lat--;
    end
    bus.imem_rdata = bus.imem_ack ? word_of(bus.imem_addr) : $urandom;
    if (rand_mode) begin
      bus.instr_ready = ($urandom_range(99, 0) < p_rdy);
      bus.stall       = ($urandom_range(99, 0) < p_stall);
      bus.redirect    = ($urandom_range(99, 0) < p_redir);
      sel = $urandom_range(2, 0);
      if (sel == 0) bus.redirect_pc = $urandom;
      else if (sel == 1) bus.redirect_pc = 32'hFFFF_FFF0 | $urandom_range(15, 0);
      else bus.redirect_pc = $urandom_range(255, 0);
    end else begin
      bus.redirect = 0;
    end
  endtask

  task automatic do_reset();
    #2 rst = 0;
    repeat (3) step();
    rst = 1;
    req_log.delete();
    acc_log.delete();
  endtask

  task automatic wait_req(input logic [31:0] a, input int budget, input string nm);
    int k = 0;
    while (!(bus.imem_req && bus.imem_addr == a) && k < budget) begin step(); k++; end
    chk(nm, bus.imem_req && bus.imem_addr == a, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.imem_ack = 0; bus.imem_rdata = 0; bus.instr_ready = 1;
    bus.redirect = 0; bus.redirect_pc = 0; bus.stall = 0;
    rand_mode = 0; lat_lo = 0; lat_hi = 0; busy = 0; lat = 0;
    p_rdy = 70; p_stall = 20; p_redir = 5;

    // Sequential fetch, and the wrapping instance alongside it.
    do_reset();
    for (int k = 0; k < 60 && acc_log.size() < 4; k++) step();
    chk("seq_count", acc_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("seq_acc_pc", qat(acc_log, i), i * 4);
      chk("seq_req_addr", qat(req_log, i), i * 4);
    end
    chk("wrap_first_req", qat(w_req_log, 0), 32'hFFFF_FFFC);
    chk("wrap_second_req", qat(w_req_log, 1), 32'h0000_0000);
    chk("wrap_second_pc", qat(w_acc_log, 1), 32'h0000_0000);

    // Backpressure: two words buffered, no further requests, then drain in order.
    bus.instr_ready = 0;
    do_reset();
    repeat (20) step();
    chk("bp_valid", bus.instr_valid, 1'b1);
    chk("bp_req_idle", bus.imem_req, 1'b0);
    chk("bp_nreq", req_log.size(), 2);
    chk("bp_head_pc", bus.instr_pc, 32'h0);
    bus.instr_ready = 1;
    for (int k = 0; k < 30 && req_log.size() < 3; k++) step();
    chk("bp_acc0", qat(acc_log, 0), 32'h0);
    chk("bp_acc1", qat(acc_log, 1), 32'h4);
    chk("bp_resume", qat(req_log, 2), 32'h8);

    // Redirect with a request outstanding.
    lat_lo = 2; lat_hi = 2;
    do_reset();
    wait_req(32'h8, 60, "rc_reach8");
    bus.redirect = 1; bus.redirect_pc = 32'h0000_0103;
    step();
    chk("rc_hold_req", bus.imem_req, 1'b1);
    chk("rc_hold_addr", bus.imem_addr, 32'h8);
    chk("rc_flush_valid", bus.instr_valid, 1'b0);
    wait_req(32'h100, 40, "rc_new_req");
    repeat (12) step();
    chk("rc_acc0", qat(acc_log, 0), 32'h0);
    chk("rc_acc1", qat(acc_log, 1), 32'h4);
    chk("rc_acc2", qat(acc_log, 2), 32'h100);

    // Redirect coincident with the ack for address 4.
    lat_lo = 0; lat_hi = 0;
    do_reset();
    wait_req(32'h4, 40, "rd_reach4");
    chk("rd_ack_now", bus.imem_ack, 1'b1);
    bus.redirect = 1; bus.redirect_pc = 32'h40;
    step();
    wait_req(32'h40, 20, "rd_new_req");
    repeat (10) step();
    chk("rd_acc0", qat(acc_log, 0), 32'h0);
    chk("rd_acc1", qat(acc_log, 1), 32'h40);

    // Stall while a request is outstanding.
    lat_lo = 1; lat_hi = 1;
    do_reset();
    wait_req(32'h4, 40, "st_reach4");
    bus.stall = 1;
    repeat (10) step();
    chk("st_nreq", req_log.size(), 2);
    chk("st_req_low", bus.imem_req, 1'b0);
    chk("st_acc_n", acc_log.size(), 2);
    bus.stall = 0;
    wait_req(32'h8, 20, "st_resume8");

    // Randomised traffic against the model.
    lat_lo = 0; lat_hi = 3; rand_mode = 1;
    do_reset();
    repeat (3000) step();
    chk("rand_progress", acc_log.size() > 100, 1'b1);
    p_rdy = 25; p_redir = 2; p_stall = 40;
    repeat (1500) step();

    // Asynchronous reset in the middle of a request.
    rand_mode = 0; bus.redirect = 0; bus.stall = 0;
    bus.instr_ready = 0; lat_lo = 3; lat_hi = 3;
    do_reset();
    for (int k = 0; k < 40 && !(bus.imem_req && bus.instr_valid); k++) step();
    chk("ar_busy", bus.imem_req && bus.instr_valid, 1'b1);
    #3 rst = 0;
    #1;
    chk("ar_req", bus.imem_req, 1'b0);
    chk("ar_addr", bus.imem_addr, 32'h0);
    chk("ar_valid", bus.instr_valid, 1'b0);
    chk("ar_instr", bus.instr, 32'h0);
    chk("ar_opcode", {26'd0, bus.opcode}, 32'h0);
    chk("ar_funct", {26'd0, bus.funct}, 32'h0);
    chk("ar_pc", bus.instr_pc, 32'h0);
    chk("ar_wrap_addr", wbus.imem_addr, 32'hFFFF_FFFC);
    repeat (2) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
